// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART byte receive controller driven by an external mid-bit strobe
// Frames start/DATA_BITS data (LSB first)/stop and reports each frame as rx_valid or frame_err.
module uart_rx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 count_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rx_s, rx_d;
    logic                 bps_d, bps_rise;
    logic [DATA_BITS-1:0] shift_reg, shift_nx, rx_data_nx;
    logic [CW-1:0]        bit_cnt, bit_cnt_nx;
    logic                 rx_valid_nx, frame_err_nx;

    // rx is asynchronous: two synchronizer stages plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            bps_d   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            bps_d   <= bps_clk;
        end
    end

    assign bps_rise = bps_clk & ~bps_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            bit_cnt   <= bit_cnt_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        shift_nx     = shift_reg;
        bit_cnt_nx   = bit_cnt;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) state_nx = START;
            end
            START: begin
                if (bps_rise) begin
                    if (!rx_s) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (bps_rise) begin
                    shift_nx   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_nx = bit_cnt + CW'(1);
                    if (bit_cnt == CW'(DATA_BITS - 1)) state_nx = STOP;
                end
            end
            STOP: begin
                if (bps_rise) begin
                    if (rx_s) begin
                        rx_data_nx  = shift_reg;
                        rx_valid_nx = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // a held-low (break) line must not look like a fresh start edge
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign count_sig = (state == START) || (state == DATA) || (state == STOP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame with a behavioural bit-rate generator
module tb_uart_rx_frame;
    localparam int BIT  = 40;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       bps_clk;
    logic       count_sig, rx_valid, frame_err, busy;
    logic [7:0] rx_data;

    logic       gen_bps = 1'b0;
    logic       ext_bps = 1'b0;
    int         gen_cnt = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_rx_frame #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bps_clk   (bps_clk),
        .count_sig (count_sig),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // bit-rate generator: counts only while enabled, strobes once per bit period near mid-bit
    always @(posedge clk) begin
        if (!count_sig) begin
            gen_cnt <= 0;
            gen_bps <= 1'b0;
        end else begin
            gen_cnt <= (gen_cnt == BIT - 1) ? 0 : gen_cnt + 1;
            gen_bps <= (gen_cnt == HALF);
        end
    end

    assign bps_clk = gen_bps | ext_bps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse at %0t",
                         rx_valid, frame_err, $time);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        if (stop_ok) begin
            sb.push_back('{1'b0, d});
            last_good = d;
        end else begin
            sb.push_back('{1'b1, last_good});
        end
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = stop_ok;
        wait_clk(BIT);
        check("count_sig_after_frame", {31'd0, count_sig}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_sig"}, {31'd0, count_sig}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit         cs_seen;
        logic [7:0] d;
        bit         ok;
        int         gap;

        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        send_frame(8'hA5, 1'b1);
        wait_clk(BIT);

        // false start shorter than half a bit
        cs_seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 12 + BIT; i++) begin
            if (i == 12) rx = 1'b1;
            wait_clk(1);
            if (count_sig) cs_seen = 1'b1;
        end
        check("false_start_cs_seen", {31'd0, cs_seen}, 32'd1);
        check("false_start_idle", {31'd0, busy}, 32'd0);
        check("false_start_cs_low", {31'd0, count_sig}, 32'd0);

        // bad stop followed by a break of three bit times
        send_frame(8'h3C, 1'b0);
        cs_seen = 1'b0;
        for (int i = 0; i < 3 * BIT; i++) begin
            wait_clk(1);
            if (count_sig) cs_seen = 1'b1;
        end
        check("break_no_restart", {31'd0, cs_seen}, 32'd0);
        check("break_wait_high_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_clk(BIT);
        check("break_released_idle", {31'd0, busy}, 32'd0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(BIT);

        // reset during the fifth data bit of 0x81
        rx = 1'b0;
        wait_clk(BIT);
        d = 8'h81;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        last_good = 8'h00;
        rx = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h5A, 1'b1);
        wait_clk(BIT);

        // idle line with a free-running external strobe
        cs_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            ext_bps = ((i % 7) < 3);
            wait_clk(1);
            if (count_sig) cs_seen = 1'b1;
        end
        ext_bps = 1'b0;
        check("idle_strobe_no_cs", {31'd0, cs_seen}, 32'd0);

        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, BIT);
            send_frame(d, ok);
            rx = 1'b1;
            if (!ok) wait_clk(BIT);
            wait_clk(gap);
        end

        for (int i = 0; i < 20 * BIT && sb.size() != 0; i++) wait_clk(1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
